// File: rtl/regfile_pkg.sv
// Shared constants, register-number type and bus-slicing helper for the
// regfile_sb register file.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NRD   = 2;

    // Widest flattened bus and widest single field the helper can slice.
    localparam int MAX_BUS   = 256;
    localparam int MAX_FIELD = 64;

    typedef logic [$clog2(DEF_DEPTH)-1:0] reg_num_t;

    // Returns field k of width w from a flattened multi-port bus.
    function automatic logic [MAX_FIELD-1:0] port_field(input logic [MAX_BUS-1:0] bus,
                                                        input int k,
                                                        input int w);
        logic [MAX_BUS-1:0] mask;
        mask = (MAX_BUS'(1) << w) - MAX_BUS'(1);
        return MAX_FIELD'((bus >> (k * w)) & mask);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/scoreboard bus of regfile_sb; the issue logic is the master.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD
);
    localparam int AW = $clog2(DEPTH);

    logic [NRD*AW-1:0]    rn;
    logic [NRD*WIDTH-1:0] q;
    logic [NRD-1:0]       q_busy;
    logic                 we;
    logic [AW-1:0]        wn;
    logic [WIDTH-1:0]     d;
    logic                 set_en;
    logic [AW-1:0]        set_n;
    logic [DEPTH-1:0]     busy_vec;

    modport master (output rn, we, wn, d, set_en, set_n,
                    input  q, q_busy, busy_vec);
    modport slave  (input  rn, we, wn, d, set_en, set_n,
                    output q, q_busy, busy_vec);

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with set-over-clear priority and busy read muxes.
// REGFILE_BYPASS_EN: a same-cycle clear is forwarded to q_busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    parameter  int NRD   = DEF_NRD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             i_we,
    input  logic [AW-1:0]    i_wn,
    input  logic             i_set_en,
    input  logic [AW-1:0]    i_set_n,
    input  logic [AW-1:0]    i_rn [NRD],
    output logic [NRD-1:0]   o_q_busy,
    output logic [DEPTH-1:0] o_busy_vec
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;

    // NOTE: default first so no path leaves w_busy_nxt unassigned (no latch);
    // the set is applied after the clear so a collision keeps the bit set.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_we)     w_busy_nxt[i_wn]    = 1'b0;
        if (i_set_en) w_busy_nxt[i_set_n] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) r_busy <= '0;
        else       r_busy <= w_busy_nxt;
    end

`ifdef REGFILE_BYPASS_EN
    // A retiring write clears early unless a new producer claims the same register.
    logic w_clr_fwd;
    assign w_clr_fwd = i_we && clrn && (i_wn != '0) && !(i_set_en && (i_set_n == i_wn));
`endif

    always_comb begin
        o_q_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            o_q_busy[k] = r_busy[i_rn[k]];
`ifdef REGFILE_BYPASS_EN
            if (w_clr_fwd && (i_rn[k] == i_wn)) o_q_busy[k] = 1'b0;
`endif
        end
    end

    assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port GPR file (register 0 hardwired to zero) with busy scoreboard.
// REGFILE_BYPASS_EN: write-through forwarding of d to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD
) (
    input  logic         clk,
    input  logic         clrn,
    regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [AW-1:0]        w_rn  [NRD];
    logic [WIDTH-1:0]     w_q   [NRD];
    logic [NRD*WIDTH-1:0] w_q_flat;
    logic                 w_wr_act;

    assign w_wr_act = bus.we && (bus.wn != '0);

    // NOTE: the array is reset because reset must make every read return 0 at once.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_act) begin
            r_mem[bus.wn] <= bus.d;
        end
    end

    // Entry 0 is never written, so it holds its reset value of zero.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign w_rn[k] = AW'(port_field(MAX_BUS'(bus.rn), k, AW));
`ifdef REGFILE_BYPASS_EN
        assign w_q[k] = (w_wr_act && clrn && (w_rn[k] == bus.wn)) ? bus.d : r_mem[w_rn[k]];
`else
        assign w_q[k] = r_mem[w_rn[k]];
`endif
    end

    always_comb begin
        w_q_flat = '0;
        for (int k = 0; k < NRD; k++) w_q_flat[k*WIDTH +: WIDTH] = w_q[k];
    end

    assign bus.q = w_q_flat;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk        (clk),
        .clrn       (clrn),
        .i_we       (bus.we),
        .i_wn       (bus.wn),
        .i_set_en   (bus.set_en),
        .i_set_n    (bus.set_n),
        .i_rn       (w_rn),
        .o_q_busy   (bus.q_busy),
        .o_busy_vec (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a 32x32/2-port and a 16-bit/8-deep/4-port instance
// driven in lockstep and compared every cycle against an array model.
module tb_regfile_sb;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    logic cmp_en = 1'b0;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    regfile_sb_if #(.WIDTH(32), .DEPTH(32), .NRD(2)) if_a ();
    regfile_sb_if #(.WIDTH(16), .DEPTH(8),  .NRD(4)) if_b ();

    regfile_sb #(.WIDTH(32), .DEPTH(32), .NRD(2)) u_dut_a (.clk(clk), .clrn(clrn), .bus(if_a));
    regfile_sb #(.WIDTH(16), .DEPTH(8),  .NRD(4)) u_dut_b (.clk(clk), .clrn(clrn), .bus(if_b));

    // Architectural model: register contents and busy bits.
    logic [31:0] mem_a  [32];
    logic        busy_a [32];
    logic [15:0] mem_b  [8];
    logic        busy_b [8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin mem_a[i] = '0; busy_a[i] = 1'b0; end
        for (int i = 0; i < 8;  i++) begin mem_b[i] = '0; busy_b[i] = 1'b0; end
    endtask

    task automatic drive(input logic we, input logic [4:0] wn, input logic [31:0] d,
                         input logic se, input logic [4:0] sn,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] r3);
        if_a.we = we; if_a.wn = wn;      if_a.d = d;        if_a.set_en = se; if_a.set_n = sn;
        if_a.rn = {r1, r0};
        if_b.we = we; if_b.wn = wn[2:0]; if_b.d = d[15:0]; if_b.set_en = se; if_b.set_n = sn[2:0];
        if_b.rn = {r3[2:0], r2[2:0], r1[2:0], r0[2:0]};
    endtask

    // One rising edge; the model takes the write, then the clear, then the set.
    task automatic clock_edge();
        @(negedge clk);
        @(posedge clk);
        if (clrn) begin
            if (if_a.we && if_a.wn != 0) mem_a[if_a.wn] = if_a.d;
            if (if_a.we) busy_a[if_a.wn] = 1'b0;
            if (if_a.set_en && if_a.set_n != 0) busy_a[if_a.set_n] = 1'b1;
            if (if_b.we && if_b.wn != 0) mem_b[if_b.wn] = if_b.d;
            if (if_b.we) busy_b[if_b.wn] = 1'b0;
            if (if_b.set_en && if_b.set_n != 0) busy_b[if_b.set_n] = 1'b1;
        end
        #1;
    endtask

    task automatic compare_all();
        logic [31:0] eq_a;
        logic [15:0] eq_b;
        logic        eb;
        logic [31:0] ev_a;
        logic [7:0]  ev_b;
        int          r;
        for (int k = 0; k < 2; k++) begin
            r    = int'(if_a.rn[k*5 +: 5]);
            eq_a = mem_a[r];
            eb   = busy_a[r];
`ifdef REGFILE_BYPASS_EN
            if (clrn && if_a.we && if_a.wn != 0 && int'(if_a.wn) == r) begin
                eq_a = if_a.d;
                if (!(if_a.set_en && if_a.set_n == if_a.wn)) eb = 1'b0;
            end
`endif
            check($sformatf("a_q%0d", k),      if_a.q[k*32 +: 32], eq_a);
            check($sformatf("a_q_busy%0d", k), if_a.q_busy[k],     eb);
        end
        for (int k = 0; k < 4; k++) begin
            r    = int'(if_b.rn[k*3 +: 3]);
            eq_b = mem_b[r];
            eb   = busy_b[r];
`ifdef REGFILE_BYPASS_EN
            if (clrn && if_b.we && if_b.wn != 0 && int'(if_b.wn) == r) begin
                eq_b = if_b.d;
                if (!(if_b.set_en && if_b.set_n == if_b.wn)) eb = 1'b0;
            end
`endif
            check($sformatf("b_q%0d", k),      if_b.q[k*16 +: 16], eq_b);
            check($sformatf("b_q_busy%0d", k), if_b.q_busy[k],     eb);
        end
        for (int i = 0; i < 32; i++) ev_a[i] = busy_a[i];
        for (int i = 0; i < 8;  i++) ev_b[i] = busy_b[i];
        check("a_busy_vec", if_a.busy_vec, ev_a);
        check("b_busy_vec", if_b.busy_vec, ev_b);
    endtask

    always @(negedge clk) if (cmp_en) compare_all();

    initial begin
        logic [31:0] dv;
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        clrn   = 1'b1;
        cmp_en = 1'b1;
        check("rst_q_a",        if_a.q,        64'h0);
        check("rst_busy_vec_a", if_a.busy_vec, 32'h0);
        check("rst_busy_vec_b", if_b.busy_vec, 8'h0);
        @(posedge clk); #1;

        // Write/read on every port
        drive(1, 13, 32'h12345678, 0, 0, 13, 13, 13, 13); clock_edge();
        check("wr13_a", if_a.q, {2{32'h12345678}});
        check("wr13_b", if_b.q, {4{16'h5678}});
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0); clock_edge();
        check("wr_r0_a", if_a.q, 64'h0);
        check("wr_r0_b", if_b.q, 64'h0);

        // Scoreboard set, clear by write, set of register 0
        drive(0, 0, 0, 1, 7, 7, 0, 7, 0); clock_edge();
        check("set7_qb_a",  if_a.q_busy,   2'b01);
        check("set7_qb_b",  if_b.q_busy,   4'b0101);
        check("set7_vec_a", if_a.busy_vec, 32'h80);
        drive(1, 7, 32'h777, 0, 0, 7, 7, 7, 7); clock_edge();
        check("clr7_qb_a", if_a.q_busy, 2'b00);
        check("clr7_q_a",  if_a.q,      {2{32'h777}});
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0); clock_edge();
        check("set0_vec_a", if_a.busy_vec, 32'h0);
        check("set0_vec_b", if_b.busy_vec, 8'h0);

        // Collisions
        drive(1, 9, 32'hA5, 1, 9, 9, 9, 9, 9); clock_edge();
        check("coll_q_a",   if_a.q,        {2{32'hA5}});
        check("coll_vec_a", if_a.busy_vec, 32'h200);
        check("coll_vec_b", if_b.busy_vec, 8'h02);
        drive(1, 4, 32'h44, 1, 3, 3, 4, 3, 4); clock_edge();
        check("diff_vec_a", if_a.busy_vec, 32'h208);
        check("diff_vec_b", if_b.busy_vec, 8'h0A);
        check("diff_qb_a",  if_a.q_busy,   2'b01);

        // Same-cycle write and read
        drive(1, 2, 32'h11, 0, 0, 2, 2, 2, 2); clock_edge();
        drive(1, 2, 32'h55, 0, 0, 2, 0, 0, 0); #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_a", if_a.q[31:0], 32'h55);
`else
        check("byp_same_a", if_a.q[31:0], 32'h11);
`endif
        clock_edge();
        check("byp_next_a", if_a.q[31:0], 32'h55);
        drive(0, 0, 0, 1, 2, 2, 0, 0, 0); clock_edge();
        drive(1, 2, 32'h66, 0, 0, 2, 0, 0, 0); #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_busy_a", if_a.q_busy[0], 1'b0);
`else
        check("byp_busy_a", if_a.q_busy[0], 1'b1);
`endif
        clock_edge();
        check("byp_busy_next_a", if_a.q_busy[0], 1'b0);

        // Asynchronous reset in the middle of a write
        drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 5, 5); clock_edge();
        check("pre_rst_a", if_a.q[31:0], 32'hDEADBEEF);
        check("pre_rst_b", if_b.q[15:0], 16'hBEEF);
        drive(1, 5, 32'h1, 1, 6, 5, 5, 5, 5); #2;
        clrn = 1'b0;
        model_clear();
        #1;
        check("rst_mid_q_a",   if_a.q,        64'h0);
        check("rst_mid_q_b",   if_b.q,        64'h0);
        check("rst_mid_vec_a", if_a.busy_vec, 32'h0);
        check("rst_mid_vec_b", if_b.busy_vec, 8'h0);
        clock_edge();
        check("rst_edge_q_a",   if_a.q,        64'h0);
        check("rst_edge_vec_a", if_a.busy_vec, 32'h0);
        clrn = 1'b1;
        drive(1, 5, 32'h77, 0, 0, 5, 5, 5, 5); clock_edge();
        check("post_rst_wr_a", if_a.q, {2{32'h77}});

        // Every address 1..7 and port slicing
        for (int a = 1; a < 8; a++) begin
            dv = 32'h11111111 * 32'(a);
            drive(1, 5'(a), dv, 0, 0, 5'(a), 5'(a), 5'(a), 5'(a)); clock_edge();
        end
        drive(0, 0, 0, 0, 0, 1, 3, 5, 7); clock_edge();
        check("sweep_q_a", if_a.q, {32'h33333333, 32'h11111111});
        check("sweep_q_b", if_b.q, {16'h7777, 16'h5555, 16'h3333, 16'h1111});
        for (int a = 1; a < 8; a++) begin
            drive(0, 0, 0, 1, 5'(a), 5'(a), 0, 0, 0); clock_edge();
        end
        check("sweep_vec_a", if_a.busy_vec, 32'hFE);
        check("sweep_vec_b", if_b.busy_vec, 8'hFE);
        drive(0, 0, 0, 0, 0, 0, 2, 4, 6); #1;
        check("sweep_qb_b", if_b.q_busy, 4'b1110);
        clock_edge();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
